line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving pixel width in bits.
REQ-002 The block SHALL have parameter PIC_WIDTH, default 480, giving pixels per line (range 3..512).
REQ-003 The block SHALL have parameter PIC_HEIGHT, default 272, giving lines per frame (range 3..1024).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 frame_start  input  1  one-cycle pulse; resynchronises counters to row 0, column 0.
REQ-007 valid_in  input  1  din carries a valid pixel this cycle.
REQ-008 din  input  WIDTH  raster-order pixel stream.
REQ-009 valid_out  output  1  dout1..dout3 carry a valid column triple.
REQ-010 dout1  output  WIDTH  pixel from line r-2 (oldest), same column.
REQ-011 dout2  output  WIDTH  pixel from line r-1, same column.
REQ-012 dout3  output  WIDTH  pixel from current line r (the din value).

Function
REQ-013 The block SHALL hold two line memories (A, B), each PIC_WIDTH x WIDTH, addressed by the column counter.
REQ-014 The column counter (9 bits) SHALL increment on each valid_in cycle and wrap from PIC_WIDTH-1 to 0.
REQ-015 The row counter (10 bits) SHALL increment on each column wrap and wrap from PIC_HEIGHT-1 to 0.
REQ-016 Counters and memories SHALL hold when valid_in=0; gaps of any length SHALL NOT corrupt alignment.
REQ-017 On a valid_in cycle, the block SHALL read A[col] and B[col] before writing; it SHALL write B[col]<=A[col] and A[col]<=din (read-before-write).
REQ-018 Outputs SHALL be registered with latency 1: dout3<=din, dout2<=old A[col], dout1<=old B[col].
REQ-019 The FSM SHALL have states FILL0 (row 0), FILL1 (row 1) and RUN (rows 2..PIC_HEIGHT-1).
REQ-020 FSM transitions SHALL occur only on column wrap: FILL0->FILL1, FILL1->RUN, RUN->FILL0 on a wrap of row PIC_HEIGHT-1, otherwise RUN->RUN.
REQ-021 valid_out SHALL be 1 in the cycle after a valid_in cycle accepted in RUN; otherwise 0.
REQ-022 In FILL0/FILL1, dout1..dout3 SHALL still update per REQ-018, but valid_out SHALL stay 0.
REQ-023 With frame_start=1, the block SHALL force col=0, row=0, state=FILL0 before the same-cycle pixel is processed.
REQ-024 If valid_in=1 in that same cycle, that pixel SHALL be treated as row 0, column 0 and the column counter SHALL advance to 1.
REQ-025 A frame_start mid-line or mid-frame SHALL discard the partial line, and valid_out SHALL be 0 from the next cycle until 2 full lines are refilled.
REQ-026 The block SHALL have no backpressure: one pixel in per valid_in cycle, and at most one triple out per cycle.
REQ-027 Memory contents SHALL NOT be cleared by reset or frame_start; priming via FSM masks stale data.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set col=0, row=0, state=FILL0, valid_out=0 and dout1=dout2=dout3=0.
REQ-029 rst SHALL take priority over frame_start and valid_in in the same cycle.
REQ-030 After rst deasserts, the first valid pixel SHALL be row 0, column 0.

Verification (bench uses PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=8, pixel value = row*16+col)
REQ-031 Stream a full frame with continuous valid_in -> valid_out=0 for the first 8 pixels; first valid_out gives dout1=0x00, dout2=0x10, dout3=0x20; last valid_out gives 0x13/0x23/0x33.
REQ-032 Stream the same frame with valid_in toggling 1,0,1,0 -> identical output triples, with valid_out only in cycles following accepted pixels.
REQ-033 Stream two back-to-back frames -> valid_out drops after pixel 0x33; second frame re-primes and gives no output until its pixel 0x20 (first triple 0x00/0x10/0x20).
REQ-034 Pulse frame_start with valid_in at pixel 0x21 of frame 1 -> that pixel is taken as row 0, column 0; valid_out=0 for the next 8 accepted pixels.
REQ-035 Assert rst mid-RUN together with valid_in=1 and frame_start=1 -> next cycle valid_out=0, all dout=0, col=0, row=0, state=FILL0.
REQ-036 Stream with PIC_WIDTH=512 -> column wrap at 511 is exact, with no 9-bit overflow and correct triple at column 511.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Three-row raster line buffer: emits a vertical column triple (rows r-2, r-1, r)
// for every accepted pixel once two full lines of the current frame are primed.
module line_buffer_3row #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned PIC_WIDTH  = 480,
    parameter int unsigned PIC_HEIGHT = 272
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);

    localparam int unsigned CW = 9;
    localparam int unsigned RW = 10;
    localparam int unsigned AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d, state_eff;
    logic [CW-1:0]     col_q, col_d, col_eff;
    logic [RW-1:0]     row_q, row_d, row_eff;
    logic              valid_out_q, valid_out_d;
    logic [WIDTH-1:0]  dout1_q, dout1_d;
    logic [WIDTH-1:0]  dout2_q, dout2_d;
    logic [WIDTH-1:0]  dout3_q, dout3_d;
    logic [AW-1:0]     idx;
    logic [WIDTH-1:0]  rd_a, rd_b;
    logic              col_wrap;

    logic [WIDTH-1:0]  mem_a [PIC_WIDTH];
    logic [WIDTH-1:0]  mem_b [PIC_WIDTH];

    // frame_start re-aligns position before the same-cycle pixel is handled
    always_comb begin
        col_eff   = frame_start ? '0    : col_q;
        row_eff   = frame_start ? '0    : row_q;
        state_eff = frame_start ? FILL0 : state_q;
        idx       = col_eff[AW-1:0];
        rd_a      = mem_a[idx];
        rd_b      = mem_b[idx];
        col_wrap  = (col_eff == CW'(PIC_WIDTH - 1));

        col_d       = col_eff;
        row_d       = row_eff;
        state_d     = state_eff;
        valid_out_d = 1'b0;
        dout1_d     = dout1_q;
        dout2_d     = dout2_q;
        dout3_d     = dout3_q;

        if (valid_in) begin
            dout3_d     = din;
            dout2_d     = rd_a;
            dout1_d     = rd_b;
            valid_out_d = (state_eff == RUN);
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_eff == RW'(PIC_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
                unique case (state_eff)
                    FILL0:   state_d = FILL1;
                    FILL1:   state_d = RUN;
                    RUN:     state_d = (row_eff == RW'(PIC_HEIGHT - 1)) ? FILL0 : RUN;
                    default: state_d = FILL0;
                endcase
            end else begin
                col_d = col_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL0;
            col_q       <= '0;
            row_q       <= '0;
            valid_out_q <= 1'b0;
            dout1_q     <= '0;
            dout2_q     <= '0;
            dout3_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            valid_out_q <= valid_out_d;
            dout1_q     <= dout1_d;
            dout2_q     <= dout2_d;
            dout3_q     <= dout3_d;
        end
    end

    // Line memories shift down one row per accepted pixel; never cleared
    always_ff @(posedge clk) begin
        if (!rst && valid_in) begin
            mem_b[idx] <= rd_a;
            mem_a[idx] <= din;
        end
    end

    assign valid_out = valid_out_q;
    assign dout1     = dout1_q;
    assign dout2     = dout2_q;
    assign dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed scoreboard bench for line_buffer_3row: a 4x4 instance for framing,
// gaps, frame_start and reset, plus a 512-wide instance for the column wrap.
module tb_line_buffer_3row;

    logic       clk = 1'b0;
    logic       rst, frame_start, valid_in;
    logic [7:0] din;
    logic       valid_out;
    logic [7:0] dout1, dout2, dout3;

    logic       w_rst, w_fs, w_valid;
    logic [7:0] w_din;
    logic       w_valid_out;
    logic [7:0] w_dout1, w_dout2, w_dout3;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] exp_q   [$];
    logic [23:0] exp_w_q [$];
    logic [7:0]  hist    [4][4];
    logic [7:0]  hist_w  [3][512];
    int m_row = 0, m_col = 0;
    int w_row = 0, w_col = 0;

    always #5 clk = ~clk;

    line_buffer_3row #(.WIDTH(8), .PIC_WIDTH(4), .PIC_HEIGHT(4)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .valid_in(valid_in), .din(din),
        .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3)
    );

    line_buffer_3row #(.WIDTH(8), .PIC_WIDTH(512), .PIC_HEIGHT(3)) dut_w (
        .clk(clk), .rst(w_rst), .frame_start(w_fs), .valid_in(w_valid), .din(w_din),
        .valid_out(w_valid_out), .dout1(w_dout1), .dout2(w_dout2), .dout3(w_dout3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock on the 4x4 instance; the model tracks logical frame position
    task automatic step(input logic r, input logic fs, input logic v, input logic [7:0] px);
        logic exp_v;
        logic [23:0] t;
        rst = r; frame_start = fs; valid_in = v; din = px;
        exp_v = 1'b0;
        if (r) begin
            m_row = 0; m_col = 0;
        end else begin
            if (fs) begin m_row = 0; m_col = 0; end
            if (v) begin
                if (m_row >= 2) begin
                    exp_v = 1'b1;
                    exp_q.push_back({hist[m_row-2][m_col], hist[m_row-1][m_col], px});
                end
                hist[m_row][m_col] = px;
                if (m_col == 3) begin
                    m_col = 0;
                    m_row = (m_row == 3) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
        @(posedge clk); #1;
        check("valid_out", 32'(valid_out), 32'(exp_v));
        if (exp_v) begin
            t = exp_q.pop_front();
            check("triple", 32'({dout1, dout2, dout3}), 32'(t));
        end
        if (r) check("dout_rst", 32'({dout1, dout2, dout3}), 32'h0);
    endtask

    task automatic step_w(input logic v, input logic [7:0] px);
        logic exp_v;
        logic [23:0] t;
        w_rst = 1'b0; w_fs = 1'b0; w_valid = v; w_din = px;
        exp_v = 1'b0;
        if (v) begin
            if (w_row >= 2) begin
                exp_v = 1'b1;
                exp_w_q.push_back({hist_w[w_row-2][w_col], hist_w[w_row-1][w_col], px});
            end
            hist_w[w_row][w_col] = px;
            if (w_col == 511) begin
                w_col = 0;
                w_row = (w_row == 2) ? 0 : w_row + 1;
            end else begin
                w_col++;
            end
        end
        @(posedge clk); #1;
        if (exp_v || w_col <= 1 || w_col >= 510) begin
            check("w_valid_out", 32'(w_valid_out), 32'(exp_v));
            if (exp_v) begin
                t = exp_w_q.pop_front();
                check("w_triple", 32'({w_dout1, w_dout2, w_dout3}), 32'(t));
            end
        end else if (exp_v == 1'b0 && w_valid_out !== 1'b0) begin
            check("w_valid_out_fill", 32'(w_valid_out), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; valid_in = 1'b0; din = '0;
        w_rst = 1'b1; w_fs = 1'b0; w_valid = 1'b0; w_din = '0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        w_rst = 1'b0;
        check("col_rst", 32'(dut.col_q), 32'h0);
        check("row_rst", 32'(dut.row_q), 32'h0);
        check("state_rst", 32'(dut.state_q), 32'h0);

        // continuous full frame
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                step(1'b0, 1'b0, 1'b1, 8'(r * 16 + c));

        // same frame with a gap after every pixel
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                step(1'b0, 1'b0, 1'b1, 8'(r * 16 + c));
                step(1'b0, 1'b0, 1'b0, 8'hee);
            end

        // two back-to-back frames
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    step(1'b0, 1'b0, 1'b1, 8'(r * 16 + c));

        // frame_start together with pixel 0x21
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1, 8'((k / 4) * 16 + k % 4));
        step(1'b0, 1'b1, 1'b1, 8'h21);
        check("col_after_fs", 32'(dut.col_q), 32'h1);
        for (int k = 10; k < 32; k++) step(1'b0, 1'b0, 1'b1, 8'(((k / 4) % 4) * 16 + k % 4));

        // realign with a bare frame_start, then reset mid-RUN with valid_in and frame_start
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 8'((k / 4) * 16 + k % 4));
        step(1'b1, 1'b1, 1'b1, 8'h55);
        check("col_rst2", 32'(dut.col_q), 32'h0);
        check("row_rst2", 32'(dut.row_q), 32'h0);
        check("state_rst2", 32'(dut.state_q), 32'h0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                step(1'b0, 1'b0, 1'b1, 8'(r * 16 + c + 8));

        // 512-wide instance: full 3-row frame exercising the column wrap at 511
        valid_in = 1'b0; frame_start = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 512; c++) begin
                step_w(1'b1, 8'(c + r * 37));
                if (c == 511) begin
                    check("w_col_wrap", 32'(dut_w.col_q), 32'h0);
                    check("w_row_wrap", 32'(dut_w.row_q), 32'((r + 1) % 3));
                end
            end
        step_w(1'b0, 8'h00);
        check("w_state_end", 32'(dut_w.state_q), 32'h0);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("w_queue_empty", 32'(exp_w_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
